// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
// The controller drives every select/enable; the datapath supplies opcode and mem_ready.
interface mips_multicycle_ctrl_if;
   logic [5:0] opcode;
   logic       mem_ready;
   logic [3:0] state_o;
   logic       pc_write;
   logic       pc_write_cond;
   logic       branch_ne;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_source;
   logic       ext_sel;
   logic       illegal_op;
   logic       retire;

   modport master (
      input  opcode, mem_ready,
      output state_o, pc_write, pc_write_cond, branch_ne, i_or_d, mem_read,
             mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
             alu_src_b, alu_op, pc_source, ext_sel, illegal_op, retire
   );

   modport slave (
      output opcode, mem_ready,
      input  state_o, pc_write, pc_write_cond, branch_ne, i_or_d, mem_read,
             mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
             alu_src_b, alu_op, pc_source, ext_sel, illegal_op, retire
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: fetch, decode, execute,
// memory and write-back, stalling on a single-bit memory ready handshake.
module mips_multicycle_ctrl (
   input  logic                   clk,
   input  logic                   reset,
   mips_multicycle_ctrl_if.master bus
);
   typedef enum logic [3:0] {
      FETCH    = 4'd0,  DECODE   = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
      MEMWB    = 4'd4,  MEMWR    = 4'd5,  RTYPE_EX = 4'd6, RTYPE_WB = 4'd7,
      BRANCH   = 4'd8,  JUMP     = 4'd9,  IMM_EX = 4'd10, IMM_WB = 4'd11
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;

   state_t     state_q, state_d;
   logic [5:0] op_q, op_d;

   function automatic logic is_legal(input logic [5:0] op);
      case (op)
         OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
         OP_ADDI, OP_ANDI, OP_ORI: is_legal = 1'b1;
         default:                  is_legal = 1'b0;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      case (state_q)
         FETCH:    if (bus.mem_ready) state_d = DECODE;
         DECODE: begin
            op_d = bus.opcode;
            case (bus.opcode)
               OP_LW, OP_SW:             state_d = MEMADR;
               OP_R:                     state_d = RTYPE_EX;
               OP_BEQ, OP_BNE:           state_d = BRANCH;
               OP_J:                     state_d = JUMP;
               OP_ADDI, OP_ANDI, OP_ORI: state_d = IMM_EX;
               default:                  state_d = FETCH;
            endcase
         end
         MEMADR:   state_d = (op_q == OP_SW) ? MEMWR : MEMRD;
         MEMRD:    if (bus.mem_ready) state_d = MEMWB;
         MEMWR:    if (bus.mem_ready) state_d = FETCH;
         RTYPE_EX: state_d = RTYPE_WB;
         IMM_EX:   state_d = IMM_WB;
         // Write-back, branch, jump and any unused encoding all return to fetch.
         default:  state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   // Reset gates every output so no write enable survives an aborted instruction.
   always_comb begin
      bus.state_o       = '0;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.branch_ne     = 1'b0;
      bus.i_or_d        = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.alu_op        = 2'b00;
      bus.pc_source     = 2'b00;
      bus.ext_sel       = 1'b0;
      bus.illegal_op    = 1'b0;
      bus.retire        = 1'b0;
      if (!reset) begin
         bus.state_o = state_q;
         case (state_q)
            FETCH: begin
               bus.mem_read  = 1'b1;
               bus.alu_src_b = 2'b01;
               bus.ir_write  = bus.mem_ready;
               bus.pc_write  = bus.mem_ready;
            end
            DECODE: begin
               bus.alu_src_b = 2'b11;
               bus.ext_sel   = 1'b1;
               if (!is_legal(bus.opcode)) begin
                  bus.illegal_op = 1'b1;
                  bus.retire     = 1'b1;
               end
            end
            MEMADR: begin
               bus.alu_src_a = 1'b1;
               bus.alu_src_b = 2'b10;
               bus.ext_sel   = 1'b1;
            end
            MEMRD: begin
               bus.i_or_d   = 1'b1;
               bus.mem_read = 1'b1;
            end
            MEMWB: begin
               bus.mem_to_reg = 1'b1;
               bus.reg_write  = 1'b1;
               bus.retire     = 1'b1;
            end
            MEMWR: begin
               bus.i_or_d    = 1'b1;
               bus.mem_write = 1'b1;
               bus.retire    = bus.mem_ready;
            end
            RTYPE_EX: begin
               bus.alu_src_a = 1'b1;
               bus.alu_op    = 2'b10;
            end
            RTYPE_WB: begin
               bus.reg_dst   = 1'b1;
               bus.reg_write = 1'b1;
               bus.retire    = 1'b1;
            end
            BRANCH: begin
               bus.alu_src_a     = 1'b1;
               bus.alu_op        = 2'b01;
               bus.pc_write_cond = 1'b1;
               bus.pc_source     = 2'b01;
               bus.branch_ne     = (op_q == OP_BNE);
               bus.retire        = 1'b1;
            end
            JUMP: begin
               bus.pc_write  = 1'b1;
               bus.pc_source = 2'b10;
               bus.retire    = 1'b1;
            end
            IMM_EX: begin
               // Logical immediates are zero-extended and use the logic-imm ALU op.
               bus.alu_src_a = 1'b1;
               bus.alu_src_b = 2'b10;
               bus.ext_sel   = (op_q == OP_ADDI);
               bus.alu_op    = (op_q == OP_ADDI) ? 2'b00 : 2'b11;
            end
            IMM_WB: begin
               bus.reg_write = 1'b1;
               bus.retire    = 1'b1;
            end
            default: bus.state_o = state_q;
         endcase
      end
   end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: a directed vector table, hand sequences for the
// stall/abort corners, and random instruction streams checked against a phase-list model.
module tb_mips_multicycle_ctrl;
   typedef struct packed {
      logic [3:0] st;
      logic       pcw, pwc, bne, iod, mrd, mwr, irw, rdt, m2r, rw, asa;
      logic [1:0] asb, aop, psr;
      logic       ext, ill, ret;
   } outs_t;

   typedef struct {
      string      name;
      logic       rst;
      logic [5:0] op;
      logic       mr;
      outs_t      exp;
   } vec_t;

   localparam logic [5:0] R_OP = 6'b000000, LW = 6'b100011, SW = 6'b101011;
   localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010;
   localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   mips_multicycle_ctrl_if bus ();
   mips_multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic outs_t mk(input logic [3:0] st,
                                input logic pcw, pwc, bne, iod, mrd, mwr, irw, rdt, m2r, rw, asa,
                                input logic [1:0] asb, aop, psr,
                                input logic ext, ill, ret);
      return '{st, pcw, pwc, bne, iod, mrd, mwr, irw, rdt, m2r, rw, asa, asb, aop, psr, ext, ill, ret};
   endfunction

   function automatic outs_t get_outs();
      return '{bus.state_o, bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.i_or_d,
               bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
               bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source,
               bus.ext_sel, bus.illegal_op, bus.retire};
   endfunction

   function automatic bit legal(input logic [5:0] op);
      logic [5:0] ops [9] = '{R_OP, LW, SW, BEQ, BNE, J, ADDI, ANDI, ORI};
      foreach (ops[k]) if (ops[k] == op) return 1'b1;
      return 1'b0;
   endfunction

   // Ordered list of state codes an instruction visits, ignoring stalls.
   function automatic void phases(input logic [5:0] op, output int q[$]);
      q = '{0, 1};
      if (!legal(op))                       q = q;
      else if (op == LW)                    q = '{0, 1, 2, 3, 4};
      else if (op == SW)                    q = '{0, 1, 2, 5};
      else if (op == R_OP)                  q = '{0, 1, 6, 7};
      else if (op == BEQ || op == BNE)      q = '{0, 1, 8};
      else if (op == J)                     q = '{0, 1, 9};
      else                                  q = '{0, 1, 10, 11};
   endfunction

   function automatic bit is_mem(input int code);
      return code == 0 || code == 3 || code == 5;
   endfunction

   function automatic outs_t exp_out(input int code, input logic [5:0] op, input logic mr);
      outs_t r = '0;
      r.st = 4'(code);
      case (code)
         0:  begin r.mrd = 1; r.asb = 2'b01; r.irw = mr; r.pcw = mr; end
         1:  begin r.asb = 2'b11; r.ext = 1; r.ill = !legal(op); r.ret = !legal(op); end
         2:  begin r.asa = 1; r.asb = 2'b10; r.ext = 1; end
         3:  begin r.iod = 1; r.mrd = 1; end
         4:  begin r.m2r = 1; r.rw = 1; r.ret = 1; end
         5:  begin r.iod = 1; r.mwr = 1; r.ret = mr; end
         6:  begin r.asa = 1; r.aop = 2'b10; end
         7:  begin r.rdt = 1; r.rw = 1; r.ret = 1; end
         8:  begin r.asa = 1; r.aop = 2'b01; r.pwc = 1; r.psr = 2'b01; r.bne = (op == BNE); r.ret = 1; end
         9:  begin r.pcw = 1; r.psr = 2'b10; r.ret = 1; end
         10: begin r.asa = 1; r.asb = 2'b10; r.ext = (op == ADDI); r.aop = (op == ADDI) ? 2'b00 : 2'b11; end
         11: begin r.rw = 1; r.ret = 1; end
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic check(input string nm, input outs_t act, input outs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %06h required %06h", nm, act, exp);
      end
   endtask

   // Runs one instruction; memory phases see 'stalls' not-ready cycles, or random readiness.
   task automatic run_instr(input logic [5:0] op, input int stalls, input bit rnd);
      int   q[$];
      int   cur;
      int   left;
      int   guard;
      logic mr;
      phases(op, q);
      left  = stalls;
      guard = 0;
      while (q.size() > 0) begin
         cur = q[0];
         guard++;
         if (guard > 100) begin
            checks++;
            errors++;
            $display("FAIL progress op%02h: got stuck in %0d required completion", op, cur);
            break;
         end
         @(posedge clk); #1;
         bus.opcode = (cur == 1) ? op : 6'($urandom_range(0, 63));
         if (is_mem(cur)) begin
            if (rnd)            mr = 1'($urandom_range(0, 1));
            else if (left > 0)  begin mr = 1'b0; left--; end
            else                mr = 1'b1;
         end else begin
            mr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         bus.mem_ready = mr;
         @(negedge clk);
         check($sformatf("op%02h_st%0d", op, cur), get_outs(), exp_out(cur, op, mr));
         if (!(is_mem(cur) && !mr)) begin
            void'(q.pop_front());
            left = stalls;
         end
      end
   endtask

   vec_t v[$];

   initial begin
      logic [5:0] pool [9] = '{R_OP, LW, SW, BEQ, BNE, J, ADDI, ANDI, ORI};
      logic [5:0] op;
      bus.opcode    = '0;
      bus.mem_ready = 1'b0;

      //                                    st pcw pwc bne iod mrd mwr irw rdt m2r rw asa asb aop psr ext ill ret
      v.push_back('{"rst_hold",   1, 6'h00, 1, mk(0, 0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0,  0,  0,  0,  0,  0,  0)});
      v.push_back('{"fetch_wait", 0, 6'h00, 0, mk(0, 0,  0,  0,  0,  1,  0,  0,  0,  0, 0, 0,  1,  0,  0,  0,  0,  0)});
      v.push_back('{"fetch_rdy",  0, 6'h00, 1, mk(0, 1,  0,  0,  0,  1,  0,  1,  0,  0, 0, 0,  1,  0,  0,  0,  0,  0)});
      v.push_back('{"lw_decode",  0, LW,    0, mk(1, 0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0,  3,  0,  0,  1,  0,  0)});
      v.push_back('{"lw_memadr",  0, 6'h00, 1, mk(2, 0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 1,  2,  0,  0,  1,  0,  0)});
      v.push_back('{"lw_memrd",   0, 6'h00, 1, mk(3, 0,  0,  0,  1,  1,  0,  0,  0,  0, 0, 0,  0,  0,  0,  0,  0,  0)});
      v.push_back('{"lw_memwb",   0, 6'h00, 0, mk(4, 0,  0,  0,  0,  0,  0,  0,  0,  1, 1, 0,  0,  0,  0,  0,  0,  1)});
      v.push_back('{"fetch2",     0, 6'h00, 1, mk(0, 1,  0,  0,  0,  1,  0,  1,  0,  0, 0, 0,  1,  0,  0,  0,  0,  0)});
      v.push_back('{"ill_decode", 0, 6'h3f, 1, mk(1, 0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0,  3,  0,  0,  1,  1,  1)});
      v.push_back('{"fstall1",    0, 6'h00, 0, mk(0, 0,  0,  0,  0,  1,  0,  0,  0,  0, 0, 0,  1,  0,  0,  0,  0,  0)});
      v.push_back('{"fstall2",    0, 6'h00, 0, mk(0, 0,  0,  0,  0,  1,  0,  0,  0,  0, 0, 0,  1,  0,  0,  0,  0,  0)});
      v.push_back('{"fetch3",     0, 6'h00, 1, mk(0, 1,  0,  0,  0,  1,  0,  1,  0,  0, 0, 0,  1,  0,  0,  0,  0,  0)});
      v.push_back('{"j_decode",   0, J,     0, mk(1, 0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0,  3,  0,  0,  1,  0,  0)});
      v.push_back('{"j_jump",     0, LW,    1, mk(9, 1,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0,  0,  0,  2,  0,  0,  1)});
      v.push_back('{"fetch4",     0, 6'h00, 1, mk(0, 1,  0,  0,  0,  1,  0,  1,  0,  0, 0, 0,  1,  0,  0,  0,  0,  0)});
      v.push_back('{"sw_decode",  0, SW,    1, mk(1, 0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0,  3,  0,  0,  1,  0,  0)});
      v.push_back('{"sw_memadr",  0, 6'h3f, 0, mk(2, 0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 1,  2,  0,  0,  1,  0,  0)});
      v.push_back('{"sw_memwr",   0, 6'h00, 0, mk(5, 0,  0,  0,  1,  0,  1,  0,  0,  0, 0, 0,  0,  0,  0,  0,  0,  0)});
      v.push_back('{"rst_abort",  1, 6'h00, 0, mk(0, 0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0,  0,  0,  0,  0,  0,  0)});
      v.push_back('{"post_rst",   0, 6'h00, 0, mk(0, 0,  0,  0,  0,  1,  0,  0,  0,  0, 0, 0,  1,  0,  0,  0,  0,  0)});

      foreach (v[i]) begin
         @(posedge clk); #1;
         reset         = v[i].rst;
         bus.opcode    = v[i].op;
         bus.mem_ready = v[i].mr;
         @(negedge clk);
         check(v[i].name, get_outs(), v[i].exp);
      end

      // Multi-cycle corners: stalled store, logical vs arithmetic immediates, branch senses.
      run_instr(SW, 3, 1'b0);
      run_instr(ORI, 0, 1'b0);
      run_instr(ADDI, 0, 1'b0);
      run_instr(BNE, 0, 1'b0);
      run_instr(BEQ, 0, 1'b0);
      run_instr(J, 0, 1'b0);
      run_instr(LW, 2, 1'b0);
      run_instr(R_OP, 1, 1'b0);
      run_instr(ANDI, 0, 1'b0);
      run_instr(6'h3f, 2, 1'b0);

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
         else                           op = pool[$urandom_range(0, 8)];
         run_instr(op, 0, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
